conv_sched: RTL and testbench

- Sequencing controller for the NPU's dual-lane KxK convolution datapath.
- Loads the kernel once, then walks the feature map in raster order. Each step issues one window load that fills two stride-separated windows (lane 1 at column c, lane 2 at c+stride), pulses the MAC engine, and writes the results to output memory under a valid/ready handshake.
- Sits between the top-level NPU command register and the src/kernel SRAMs, window buffers and MAC unit.

---
 rtl/npu_pkg.sv | 21 ++
 rtl/conv_addr_gen.sv | 94 +++++++++
 rtl/conv_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_conv_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and default geometry for the NPU convolution sequencer.
//   state_e   : conv_sched controller states
//   IMG_W_DEF : default square feature-map side length in pixels
//   K_DEF     : default kernel side length
package npu_pkg;

    localparam int unsigned IMG_W_DEF = 28;
    localparam int unsigned K_DEF     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLdKrn,
        StLdWin,
        StMac,
        StWr1,
        StWr2,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// KxK window address walker shared by the kernel and window load phases.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_base : restart the walk at i_base with wr = wc = 0
//   i_win_mode     : 1 = jump to the next image row after K columns, 0 = flat +1 walk
//   i_stride       : lane-2 offset from lane-1 address
//   i_issue, i_tag : a read is issued this cycle; tag travels with it
//   o_addr1/2      : current lane-1 / lane-2 read address
//   o_last         : the current issue is the final (wr = wc = K-1) one
//   o_we, o_we_tag : issue strobe and tag delayed one cycle (SRAM read latency)
//   o_row, o_col   : index of the delayed issue, 0 when o_we is low
module conv_addr_gen
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned K      = K_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_win_mode,
    input  logic [2:0]        i_stride,
    input  logic              i_issue,
    input  logic              i_tag,
    output logic [ADDR_W-1:0] o_addr1,
    output logic [ADDR_W-1:0] o_addr2,
    output logic              o_last,
    output logic              o_we,
    output logic              o_we_tag,
    output logic [1:0]        o_row,
    output logic [1:0]        o_col
);

    localparam int unsigned       CW       = $clog2(IMG_W) + 1;
    localparam logic [CW-1:0]     KM1      = CW'(K - 1);
    // From the last column of one window row to the first column of the next.
    localparam logic [ADDR_W-1:0] ROW_JUMP = ADDR_W'(IMG_W - (K - 1));

    logic [CW-1:0]     wr_q, wr_d, wc_q, wc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, tag_q;
    logic [1:0]        row_q, col_q;

    assign o_last   = (wr_q == KM1) && (wc_q == KM1);
    assign o_addr1  = addr_q;
    assign o_addr2  = addr_q + ADDR_W'(i_stride);
    assign o_we     = we_q;
    assign o_we_tag = tag_q;
    assign o_row    = row_q;
    assign o_col    = col_q;

    always_comb begin
        wr_d   = wr_q;
        wc_d   = wc_q;
        addr_d = addr_q;
        if (i_load) begin
            // Load wins over a same-cycle issue: the last issue of a phase needs no advance.
            wr_d   = '0;
            wc_d   = '0;
            addr_d = i_base;
        end else if (i_issue) begin
            if (wc_q == KM1) begin
                wc_d   = '0;
                wr_d   = wr_q + CW'(1);
                addr_d = addr_q + (i_win_mode ? ROW_JUMP : ADDR_W'(1));
            end else begin
                wc_d   = wc_q + CW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q   <= '0;
            wc_q   <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            tag_q  <= 1'b0;
            row_q  <= 2'b0;
            col_q  <= 2'b0;
        end else begin
            wr_q   <= wr_d;
            wc_q   <= wc_d;
            addr_q <= addr_d;
            we_q   <= i_issue;
            tag_q  <= i_issue & i_tag;
            row_q  <= i_issue ? wr_q[1:0] : 2'b0;
            col_q  <= i_issue ? wc_q[1:0] : 2'b0;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Dual-lane KxK convolution sequencer: loads the kernel once, then walks the
// feature map in raster order, two stride-separated windows per step.
//   i_start, i_*_base, i_stride : job command (latched on accepted start)
//   o_busy, o_done              : job status
//   o_krn_rd_en, o_krn_addr     : kernel SRAM read
//   o_src_rd_en, o_src_addr1/2  : feature-map SRAM reads, lane 1 / lane 2
//   o_krn_we, o_win_we, o_row, o_col : register-file / window-buffer writes
//   o_mac_start, i_mac_done     : MAC engine handshake
//   o_lane2_vld                 : lane-2 window lies inside the image
//   o_wr_valid/i_wr_ready, o_wr_lane, o_wr_addr : output write handshake
module conv_sched
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned K      = K_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_img_base,
    input  logic [ADDR_W-1:0] i_krn_base,
    input  logic [ADDR_W-1:0] i_out_base,
    input  logic [2:0]        i_stride,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_krn_rd_en,
    output logic [ADDR_W-1:0] o_krn_addr,
    output logic              o_src_rd_en,
    output logic [ADDR_W-1:0] o_src_addr1,
    output logic [ADDR_W-1:0] o_src_addr2,
    output logic              o_krn_we,
    output logic              o_win_we,
    output logic [1:0]        o_row,
    output logic [1:0]        o_col,
    output logic              o_mac_start,
    input  logic              i_mac_done,
    output logic              o_lane2_vld,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic              o_wr_lane,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int unsigned CW = $clog2(IMG_W) + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic [2:0]        stride_q, stride_d, stride_eff;
    logic [ADDR_W-1:0] row_base_q, row_base_d;  // img_base + r*IMG_W, kept incrementally
    logic [ADDR_W-1:0] row_step_q, row_step_d;  // stride*IMG_W, computed once per job
    logic [ADDR_W-1:0] optr_q, optr_d;
    logic              wait_q, wait_d;          // final window write still in flight
    logic              mac_seen_q;

    logic [31:0] c_step, r_step;
    logic        wrap, finish, lane2;

    logic              gen_load, gen_issue, gen_win, gen_tag;
    logic [ADDR_W-1:0] gen_base, gen_addr1, gen_addr2;
    logic              gen_last, gen_we, gen_we_tag;
    logic              krn_rd, src_rd;

    assign stride_eff = (i_stride == 3'd0) ? 3'd1 : i_stride;

    // Widened so large strides cannot wrap the small counters before the bound checks.
    assign c_step = 32'(c_q) + 32'({stride_q, 1'b0});
    assign r_step = 32'(r_q) + 32'(stride_q);
    assign wrap   = (c_step + K) > IMG_W;
    assign finish = wrap && ((r_step + K) > IMG_W);
    assign lane2  = (32'(c_q) + 32'(stride_q) + K) <= IMG_W;

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (gen_load),
        .i_base     (gen_base),
        .i_win_mode (gen_win),
        .i_stride   (stride_q),
        .i_issue    (gen_issue),
        .i_tag      (gen_tag),
        .o_addr1    (gen_addr1),
        .o_addr2    (gen_addr2),
        .o_last     (gen_last),
        .o_we       (gen_we),
        .o_we_tag   (gen_we_tag),
        .o_row      (o_row),
        .o_col      (o_col)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StLdKrn;
            StLdKrn: if (gen_last) state_d = StLdWin;
            StLdWin: if (wait_q) state_d = StMac;
            StMac:   if (i_mac_done) state_d = StWr1;
            StWr1:   if (i_wr_ready) state_d = lane2 ? StWr2 : StNext;
            StWr2:   if (i_wr_ready) state_d = StNext;
            StNext:  state_d = finish ? StDone : StLdWin;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        r_d        = r_q;
        c_d        = c_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        row_step_d = row_step_q;
        optr_d     = optr_q;
        wait_d     = wait_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    stride_d   = stride_eff;
                    row_step_d = ADDR_W'(32'(stride_eff) * IMG_W);
                    row_base_d = i_img_base;
                    r_d        = '0;
                    c_d        = '0;
                    optr_d     = i_out_base;
                end
            end
            StLdWin: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else if (gen_last) begin
                    wait_d = 1'b1;
                end
            end
            StWr1, StWr2: begin
                if (i_wr_ready) optr_d = optr_q + ADDR_W'(1);
            end
            StNext: begin
                if (wrap) begin
                    c_d        = '0;
                    r_d        = CW'(r_step);
                    row_base_d = row_base_q + row_step_q;
                end else begin
                    c_d = CW'(c_step);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q        <= '0;
            c_q        <= '0;
            stride_q   <= 3'd0;
            row_base_q <= '0;
            row_step_q <= '0;
            optr_q     <= '0;
            wait_q     <= 1'b0;
            mac_seen_q <= 1'b0;
        end else begin
            r_q        <= r_d;
            c_q        <= c_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            row_step_q <= row_step_d;
            optr_q     <= optr_d;
            wait_q     <= wait_d;
            mac_seen_q <= (state_q == StMac);
        end
    end

    // Output and walker-control logic.
    always_comb begin
        gen_load    = 1'b0;
        gen_base    = '0;
        gen_issue   = 1'b0;
        gen_win     = 1'b0;
        gen_tag     = 1'b0;
        krn_rd      = 1'b0;
        src_rd      = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_mac_start = 1'b0;
        o_lane2_vld = 1'b0;
        o_wr_valid  = 1'b0;
        o_wr_lane   = 1'b0;
        o_wr_addr   = '0;
        unique case (state_q)
            StIdle: begin
                o_busy   = 1'b0;
                gen_load = i_start;
                gen_base = i_krn_base;
            end
            StLdKrn: begin
                krn_rd    = 1'b1;
                gen_issue = 1'b1;
                gen_load  = gen_last;
                gen_base  = row_base_d + ADDR_W'(c_d);
            end
            StLdWin: begin
                gen_win     = 1'b1;
                gen_tag     = 1'b1;
                gen_issue   = ~wait_q;
                src_rd      = ~wait_q;
                o_lane2_vld = lane2;
            end
            StMac: begin
                o_mac_start = ~mac_seen_q;
                o_lane2_vld = lane2;
            end
            StWr1: begin
                o_wr_valid  = 1'b1;
                o_wr_addr   = optr_q;
                o_lane2_vld = lane2;
            end
            StWr2: begin
                o_wr_valid  = 1'b1;
                o_wr_lane   = 1'b1;
                o_wr_addr   = optr_q;
                o_lane2_vld = lane2;
            end
            StNext: begin
                gen_load = ~finish;
                gen_base = row_base_d + ADDR_W'(c_d);
            end
            StDone: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            default: o_busy = 1'b0;
        endcase
    end

    assign o_krn_rd_en = krn_rd;
    assign o_krn_addr  = krn_rd ? gen_addr1 : '0;
    assign o_src_rd_en = src_rd;
    assign o_src_addr1 = src_rd ? gen_addr1 : '0;
    assign o_src_addr2 = src_rd ? gen_addr2 : '0;
    assign o_krn_we    = gen_we & ~gen_we_tag;
    assign o_win_we    = gen_we & gen_we_tag;

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

    localparam int unsigned AW = 10;

    logic          clk, rst_n, start, mac_done, wr_ready;
    logic [AW-1:0] img_base, krn_base, out_base;
    logic [2:0]    stride;
    logic          busy, done, krn_rd_en, src_rd_en, krn_we, win_we;
    logic          mac_start, lane2_vld, wr_valid, wr_lane;
    logic [AW-1:0] krn_addr, src_addr1, src_addr2, wr_addr;
    logic [1:0]    row, col;

    conv_sched #(
        .ADDR_W (AW),
        .IMG_W  (5),
        .K      (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_img_base  (img_base),
        .i_krn_base  (krn_base),
        .i_out_base  (out_base),
        .i_stride    (stride),
        .o_busy      (busy),
        .o_done      (done),
        .o_krn_rd_en (krn_rd_en),
        .o_krn_addr  (krn_addr),
        .o_src_rd_en (src_rd_en),
        .o_src_addr1 (src_addr1),
        .o_src_addr2 (src_addr2),
        .o_krn_we    (krn_we),
        .o_win_we    (win_we),
        .o_row       (row),
        .o_col       (col),
        .o_mac_start (mac_start),
        .i_mac_done  (mac_done),
        .o_lane2_vld (lane2_vld),
        .o_wr_valid  (wr_valid),
        .i_wr_ready  (wr_ready),
        .o_wr_lane   (wr_lane),
        .o_wr_addr   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [AW-1:0] krn_q[$], a1_q[$], a2_q[$], wa_q[$];
    logic          wl_q[$];
    logic [3:0]    rc_q[$];
    int            mac_cnt, ovl_cnt, stall_bad, done_seen;

    int win_tab[9]  = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int lane_tab[9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};

    logic [53:0] all_out;
    assign all_out = {busy, done, krn_rd_en, krn_addr, src_rd_en, src_addr1, src_addr2, krn_we,
                      win_we, row, col, mac_start, lane2_vld, wr_valid, wr_lane, wr_addr};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [2:0] s, input logic [AW-1:0] kb);
        img_base = 10'h000;
        krn_base = kb;
        out_base = 10'h200;
        stride   = s;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Steps a started job cycle by cycle, recording every DUT transaction.
    task automatic run_job(input int budget, input int stall, input int inj);
        int            stall_left;
        bit            held;
        logic [AW-1:0] hold_addr;
        logic          hold_lane;
        krn_q.delete(); a1_q.delete(); a2_q.delete(); wa_q.delete(); wl_q.delete(); rc_q.delete();
        mac_cnt = 0; ovl_cnt = 0; stall_bad = 0; done_seen = 0;
        stall_left = stall; held = 1'b0; hold_addr = '0; hold_lane = 1'b0;
        for (int cyc = 0; cyc < budget && done_seen == 0; cyc++) begin
            start = (cyc == inj);
            if (cyc == inj) begin
                img_base = 10'h3c0; krn_base = 10'h2c0; out_base = 10'h080; stride = 3'd3;
            end
            if (krn_rd_en) krn_q.push_back(krn_addr);
            if (src_rd_en) begin
                a1_q.push_back(src_addr1);
                a2_q.push_back(src_addr2);
            end
            if (win_we) rc_q.push_back({row, col});
            if (krn_we && src_rd_en) ovl_cnt++;
            if (mac_start) mac_cnt++;
            mac_done = mac_start;
            if (stall_left > 0 && (wr_valid || held)) begin
                if (!held) begin
                    held = 1'b1; hold_addr = wr_addr; hold_lane = wr_lane;
                end else if (!wr_valid || wr_addr !== hold_addr || wr_lane !== hold_lane) begin
                    stall_bad++;
                end
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_valid && wr_ready) begin
                wa_q.push_back(wr_addr);
                wl_q.push_back(wr_lane);
            end
            if (done) done_seen = 1;
            @(posedge clk); #1;
        end
        start = 1'b0; mac_done = 1'b0; wr_ready = 1'b1;
        check("job_done_seen", 64'(done_seen), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; mac_done = 1'b0; wr_ready = 1'b1;
        img_base = '0; krn_base = '0; out_base = '0; stride = 3'd1;

        // Reset holds every output low even with start asserted.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(all_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_activity", 64'(all_out), 64'd0);

        // Stride 1, ready always high.
        pulse_start(3'd1, 10'h100);
        run_job(400, 0, -1);
        check("s1_krn_count", 64'(krn_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) check("s1_krn_addr", 64'(krn_q[i]), 64'h100 + 64'(i));
        for (int i = 0; i < 9; i++) begin
            check("s1_addr1", 64'(a1_q[i]), 64'(win_tab[i]));
            check("s1_addr2", 64'(a2_q[i]), 64'(win_tab[i] + 1));
            check("s1_rowcol", 64'(rc_q[i]), 64'(((i / 3) << 2) | (i % 3)));
        end
        check("s1_step2_addr1", 64'(a1_q[9]), 64'd2);
        check("s1_step3_addr1", 64'(a1_q[18]), 64'd5);
        check("s1_src_reads", 64'(a1_q.size()), 64'd54);
        check("s1_win_we", 64'(rc_q.size()), 64'd54);
        check("s1_mac_starts", 64'(mac_cnt), 64'd6);
        check("s1_krn_we_overlap", 64'(ovl_cnt), 64'd1);
        check("s1_wr_count", 64'(wa_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            check("s1_wr_addr", 64'(wa_q[i]), 64'h200 + 64'(i));
            check("s1_wr_lane", 64'(wl_q[i]), 64'(lane_tab[i]));
        end

        // Stride 2 with five cycles of backpressure on the first write.
        pulse_start(3'd2, 10'h100);
        run_job(400, 5, -1);
        check("s2_src_reads", 64'(a1_q.size()), 64'd18);
        check("s2_step2_addr1", 64'(a1_q[9]), 64'd10);
        check("s2_step2_addr2", 64'(a2_q[9]), 64'd12);
        check("s2_first_addr2", 64'(a2_q[0]), 64'd2);
        check("s2_mac_starts", 64'(mac_cnt), 64'd2);
        check("s2_stall_hold", 64'(stall_bad), 64'd0);
        check("s2_wr_count", 64'(wa_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("s2_wr_addr", 64'(wa_q[i]), 64'h200 + 64'(i));
            check("s2_wr_lane", 64'(wl_q[i]), 64'(i % 2));
        end

        // Stride 0 behaves as stride 1; a start mid-run is ignored.
        pulse_start(3'd0, 10'h100);
        run_job(400, 0, 30);
        check("s0_krn_count", 64'(krn_q.size()), 64'd9);
        check("s0_addr2_first", 64'(a2_q[0]), 64'd1);
        check("s0_addr1_last", 64'(a1_q[8]), 64'd12);
        check("s0_src_reads", 64'(a1_q.size()), 64'd54);
        check("s0_wr_count", 64'(wa_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            check("s0_wr_addr", 64'(wa_q[i]), 64'h200 + 64'(i));
            check("s0_wr_lane", 64'(wl_q[i]), 64'(lane_tab[i]));
        end

        // Reset during the window load aborts at once with no done pulse.
        pulse_start(3'd1, 10'h100);
        begin
            int n = 0;
            while (!src_rd_en && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            check("abort_reached_ldwin", 64'(src_rd_en), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'(all_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle_busy", 64'(busy), 64'd0);
        pulse_start(3'd1, 10'h180);
        check("restart_krn_rd", 64'(krn_rd_en), 64'd1);
        check("restart_krn_addr", 64'(krn_addr), 64'h180);
        run_job(400, 0, -1);
        check("restart_wr_count", 64'(wa_q.size()), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
